sdhci_rsp_receiver: RTL
=======================

// Module: sdhci_rsp_receiver
// PURPOSE
// Receives SD command-line responses (R1/R1b/R3/R6/R7 48-bit, R2 136-bit) after a command is issued.
// Sits between the SD CMD pad input and the command/auto-CMD12 sequencer.
// Detects the start bit, deserialises the response and checks end bit, CRC7 and command index.
// Returns the payload plus error flags that feed Error Interrupt Status / Auto CMD12 Error Status.
// PARAMETERS
// TimeoutCycles  64  SD clock periods (sd_clk_en_i pulses) to wait for a start bit (NCR) before timeout
// PORTS
// clk_i             in   1    system clock
// rst_i             in   1    asynchronous reset, active high
// sd_clk_en_i       in   1    one-cycle pulse per SD clock rising edge; sd_cmd_i is sampled only on these cycles
// sd_cmd_i          in   1    CMD line from pad (idle high)
// start_i           in   1    pulse: arm receiver (issued by sequencer on the cycle the command end bit is sent)
// abort_i           in   1    pulse: drop current reception, return to idle, no done_o
// rsp_long_i        in   1    1 = 136-bit R2, 0 = 48-bit; sampled with start_i
// check_index_i     in   1    compare response index with exp_index_i (ignored for R2); sampled with start_i
// check_crc_i       in   1    verify CRC7 (0 for R3); sampled with start_i
// exp_index_i       in   6    expected command index; sampled with start_i
// busy_o            out  1    high from accepted start_i until done_o (inclusive)
// done_o            out  1    one-cycle pulse: response complete or timed out
// rsp_o             out  120  payload: 48-bit -> {88'b0, bits[39:8]}; 136-bit -> bits[127:8]
// index_o           out  6    received bits[45:40] (48-bit only, 0 for R2)
// timeout_err_o     out  1    no start bit within TimeoutCycles
// crc_err_o         out  1    CRC7 mismatch (only if check_crc)
// end_bit_err_o     out  1    final bit sampled 0
// index_err_o       out  1    index_o != exp_index_i (only if check_index and 48-bit)
// BEHAVIOUR
// - Reset: state IDLE; busy_o, done_o, all error flags 0; rsp_o, index_o 0.
// - FSM IDLE -> WAIT_START -> RECEIVE -> DONE -> IDLE. All CMD sampling happens only on sd_clk_en_i cycles.
// - IDLE: start_i -> latch config, clear rsp_o/index_o/errors, timeout cnt := 0 -> WAIT_START.
// - WAIT_START: on sd_clk_en_i, sd_cmd_i==0 -> RECEIVE with bit cnt := 1 (start bit counted).
//   Otherwise cnt+1. When cnt reaches TimeoutCycles -> DONE with timeout_err_o=1; no other error set.
// - RECEIVE: shift one bit per sd_clk_en_i, MSB first. The transmission bit (bit 46/134) is captured but not checked.
// - CRC7 (x^7+x^3+1, init 0): 48-bit covers bits 47..8 (40 bits); 136-bit covers bits 127..8 (120 bits).
//   The CRC is compared with received bits 7..1.
// - After the last bit (48th/136th) -> DONE. The last bit is the end bit; sampling it 0 sets end_bit_err_o.
// - DONE: done_o=1 for exactly one clk, then IDLE.
//   rsp_o, index_o and errors are valid from done_o and held until the next accepted start_i or reset.
// - Latency: done_o asserts one clk after the sd_clk_en_i cycle that samples the end bit / the final timeout count.
// - start_i while busy_o: ignored. abort_i in any state: IDLE next cycle, no done_o, outputs keep prior values.
//   start_i and abort_i in the same cycle: abort wins, start dropped.
// - sd_clk_en_i absent: the FSM holds state and the timeout does not advance (it counts SD clocks, not clk_i).
// - Async reset mid-reception: immediately to reset values; no done_o.
// - Multiple errors may assert together (e.g. crc+index+end); each flag is independent.
// TESTING
// 1 48-bit, exp_index 12, line sends idx 12, arg 0, crc 0x7A, end 1 -> done_o, index_o=12, rsp_o=0, no errors.
// 2 48-bit, exp_index 0, line sends idx 63, arg 0, crc 0x7F -> crc_err_o=1, index_err_o=1, end_bit_err_o=0.
// 3 CMD held high after start_i -> done_o after 64 sd_clk_en_i pulses, timeout_err_o only, rsp_o=0.
// 4 136-bit R2, payload bits[127:8]=120'h0123..., valid crc -> rsp_o matches payload, no errors, index not checked.
// 5 abort_i in RECEIVE at bit 20, then new start_i and valid R1 -> no done_o for first; second completes clean.
// 6 sd_clk_en_i every 1, 2 and 4 clks; start bit delayed 5 SD clocks; end bit forced 0 -> end_bit_err_o only.

Source files
------------

// File: rtl/sdhci_rsp_receiver.sv
`default_nettype none
// ============================================================================
// Module      : sdhci_rsp_receiver
// Description : SD CMD-line response receiver. After the command sequencer
//               arms it, waits (bounded by TIMEOUT_CYCLES SD clocks) for the
//               start bit, deserialises a 48-bit (R1/R1b/R3/R6/R7) or 136-bit
//               (R2) response MSB first, and checks end bit, CRC7 and command
//               index.
// Ports       : clk_i, rst_i        - system clock, async active-high reset
//               sd_clk_en_i         - one pulse per SD clock; CMD sampled here
//               sd_cmd_i            - CMD pad input (idle high)
//               start_i / abort_i   - arm receiver / drop reception
//               rsp_long_i, check_index_i, check_crc_i, exp_index_i
//                                   - per-response config, sampled on start_i
//               busy_o, done_o      - status; done_o is a one-clk pulse
//               rsp_o, index_o      - payload and received command index
//               timeout_err_o, crc_err_o, end_bit_err_o, index_err_o
//                                   - independent error flags
// Revision    : 1.0 - initial release
// ============================================================================
module sdhci_rsp_receiver #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          sd_clk_en_i,
    input  logic          sd_cmd_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic          rsp_long_i,
    input  logic          check_index_i,
    input  logic          check_crc_i,
    input  logic [5:0]    exp_index_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [119:0]  rsp_o,
    output logic [5:0]    index_o,
    output logic          timeout_err_o,
    output logic          crc_err_o,
    output logic          end_bit_err_o,
    output logic          index_err_o
);

    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TO_W-1:0] c_TO_LIMIT = c_TO_W'(TIMEOUT_CYCLES);
    localparam logic [c_TO_W-1:0] c_TO_ONE   = c_TO_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RECV = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;

    // Latched configuration
    logic                r_long;
    logic                r_chk_idx;
    logic                r_chk_crc;
    logic [5:0]          r_exp_idx;

    // Reception datapath
    logic [c_TO_W-1:0]   r_to_cnt;
    logic [7:0]          r_bitcnt;
    logic [6:0]          r_crc;
    logic [6:0]          r_rxcrc;
    logic [119:0]        r_shift;
    logic [5:0]          r_idx_sh;

    // Registered outputs
    logic                r_busy;
    logic                r_done;
    logic [119:0]        r_rsp;
    logic [5:0]          r_index;
    logic                r_to_err;
    logic                r_crc_err;
    logic                r_end_err;
    logic                r_idx_err;

    logic [c_TO_W-1:0]   w_to_next;
    logic [7:0]          w_last;
    logic [7:0]          w_pos;
    logic                w_in_crc;
    logic                w_in_payload;
    logic                w_in_index;
    logic                w_in_rxcrc;
    logic                w_crc_fb;
    logic [6:0]          w_crc_next;

    assign w_to_next = r_to_cnt + c_TO_ONE;

    // Frame bit number of the bit being sampled now (start bit = 47 or 135).
    assign w_last = r_long ? 8'd135 : 8'd47;
    assign w_pos  = w_last - r_bitcnt;

    // The start and transmission bits of a short frame are inside CRC
    // coverage; the start bit is 0 so it leaves a zero-initialised CRC
    // unchanged and needs no special handling.
    assign w_in_crc     = (w_pos >= 8'd8) && (!r_long || (w_pos <= 8'd127));
    assign w_in_payload = (w_pos >= 8'd8) && (r_long ? (w_pos <= 8'd127) : (w_pos <= 8'd39));
    assign w_in_index   = !r_long && (w_pos >= 8'd40) && (w_pos <= 8'd45);
    assign w_in_rxcrc   = (w_pos >= 8'd1) && (w_pos <= 8'd7);

    // CRC7, polynomial x^7 + x^3 + 1, serial MSB-first update
    assign w_crc_fb   = sd_cmd_i ^ r_crc[6];
    assign w_crc_next = {r_crc[5:0], 1'b0} ^ (w_crc_fb ? 7'h09 : 7'h00);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_long    <= 1'b0;
            r_chk_idx <= 1'b0;
            r_chk_crc <= 1'b0;
            r_exp_idx <= 6'd0;
            r_to_cnt  <= '0;
            r_bitcnt  <= 8'd0;
            r_crc     <= 7'd0;
            r_rxcrc   <= 7'd0;
            r_shift   <= 120'd0;
            r_idx_sh  <= 6'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rsp     <= 120'd0;
            r_index   <= 6'd0;
            r_to_err  <= 1'b0;
            r_crc_err <= 1'b0;
            r_end_err <= 1'b0;
            r_idx_err <= 1'b0;
        end else if (abort_i) begin
            // Abort beats everything, including a simultaneous start_i.
            // Result registers are left untouched.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start_i) begin
                        r_long    <= rsp_long_i;
                        r_chk_idx <= check_index_i;
                        r_chk_crc <= check_crc_i;
                        r_exp_idx <= exp_index_i;
                        r_to_cnt  <= '0;
                        r_bitcnt  <= 8'd0;
                        r_crc     <= 7'd0;
                        r_rxcrc   <= 7'd0;
                        r_shift   <= 120'd0;
                        r_idx_sh  <= 6'd0;
                        r_rsp     <= 120'd0;
                        r_index   <= 6'd0;
                        r_to_err  <= 1'b0;
                        r_crc_err <= 1'b0;
                        r_end_err <= 1'b0;
                        r_idx_err <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (sd_clk_en_i) begin
                        if (!sd_cmd_i) begin
                            r_bitcnt <= 8'd1;
                            r_state  <= S_RECV;
                        end else if (w_to_next == c_TO_LIMIT) begin
                            r_to_err <= 1'b1;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_to_cnt <= w_to_next;
                        end
                    end
                end

                S_RECV: begin
                    if (sd_clk_en_i) begin
                        r_bitcnt <= r_bitcnt + 8'd1;
                        if (w_in_crc) begin
                            r_crc <= w_crc_next;
                        end
                        if (w_in_payload) begin
                            r_shift <= {r_shift[118:0], sd_cmd_i};
                        end
                        if (w_in_index) begin
                            r_idx_sh <= {r_idx_sh[4:0], sd_cmd_i};
                        end
                        if (w_in_rxcrc) begin
                            r_rxcrc <= {r_rxcrc[5:0], sd_cmd_i};
                        end
                        if (w_pos == 8'd0) begin
                            // End bit: every field is complete, publish results.
                            r_end_err <= !sd_cmd_i;
                            r_crc_err <= r_chk_crc && (r_crc != r_rxcrc);
                            r_idx_err <= r_chk_idx && !r_long && (r_idx_sh != r_exp_idx);
                            r_rsp     <= r_shift;
                            r_index   <= r_long ? 6'd0 : r_idx_sh;
                            r_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign rsp_o         = r_rsp;
    assign index_o       = r_index;
    assign timeout_err_o = r_to_err;
    assign crc_err_o     = r_crc_err;
    assign end_bit_err_o = r_end_err;
    assign index_err_o   = r_idx_err;

endmodule
`default_nettype wire
